// File: rtl/vend_pkg.sv
// Shared types and defaults for the vending dispense path.
package vend_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_SETTLE = 2'd2
   } state_t;

   localparam int PEND_W = 2;

   localparam int DEF_MOTOR_CYCLES  = 8;
   localparam int DEF_SETTLE_CYCLES = 2;
   localparam int DEF_QUEUE_DEPTH   = 3;
   localparam int DEF_STOCK_W       = 4;
   localparam int DEF_STOCK_INIT    = 15;

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector; the reset value of the history bit decides whether
// a level already high at reset release counts as an edge.
module rise_detect #(
   parameter logic PREV_INIT = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic rise
);

   logic prev_q;
   logic prev_d;

   always_comb begin
      prev_d = d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         prev_q <= PREV_INIT;
      end else begin
         prev_q <= prev_d;
      end
   end

   assign rise = d & ~prev_q;

endmodule

// File: rtl/dispense_controller.sv
// Queues dispense requests, runs the motor per item and tracks reserved stock.
//   state     | meaning
//   ST_IDLE   | motor off, waiting for a queued request
//   ST_RUN    | motor driven for MOTOR_CYCLES cycles
//   ST_SETTLE | motor off for SETTLE_CYCLES cycles after an item
module dispense_controller
   import vend_pkg::*;
#(
   parameter int MOTOR_CYCLES  = DEF_MOTOR_CYCLES,
   parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
   parameter int QUEUE_DEPTH   = DEF_QUEUE_DEPTH,
   parameter int STOCK_W       = DEF_STOCK_W,
   parameter int STOCK_INIT    = DEF_STOCK_INIT
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               is_dispensed,
   input  logic               refill,
   input  logic [STOCK_W-1:0] refill_count,
   output logic               motor_en,
   output logic               item_out,
   output logic               busy,
   output logic               sold_out,
   output logic [STOCK_W-1:0] stock,
   output logic [PEND_W-1:0]  pending,
   output logic               lost_sale
);

   localparam int TMAX    = (MOTOR_CYCLES > SETTLE_CYCLES) ? MOTOR_CYCLES : SETTLE_CYCLES;
   localparam int TIMER_W = (TMAX > 1) ? $clog2(TMAX) : 1;

   localparam logic [TIMER_W-1:0] MOTOR_LOAD  = TIMER_W'(MOTOR_CYCLES - 1);
   localparam logic [TIMER_W-1:0] SETTLE_LOAD = TIMER_W'(SETTLE_CYCLES - 1);
   localparam logic [TIMER_W-1:0] TIMER_ZERO  = '0;
   localparam logic [PEND_W-1:0]  PEND_FULL   = PEND_W'(QUEUE_DEPTH);
   localparam logic [PEND_W-1:0]  PEND_ONE    = PEND_W'(1);
   localparam logic [PEND_W-1:0]  PEND_ZERO   = '0;
   localparam logic [STOCK_W:0]   STOCK_MAX   = {1'b0, {STOCK_W{1'b1}}};
   localparam logic [STOCK_W-1:0] STOCK_RST   = STOCK_W'(STOCK_INIT);

   state_t               state_q, state_d;
   logic [TIMER_W-1:0]   timer_q, timer_d;
   logic [PEND_W-1:0]    pending_q, pending_d;
   logic [STOCK_W-1:0]   stock_q, stock_d;
   logic                 motor_en_q, motor_en_d;
   logic                 item_out_q, item_out_d;
   logic                 lost_sale_q, lost_sale_d;

   logic                 req;
   logic                 accept;
   logic                 start;
   logic [STOCK_W:0]     stock_sum;

   rise_detect #(
      .PREV_INIT (1'b1)
   ) u_rise (
      .clk  (clk),
      .rst  (rst),
      .d    (is_dispensed),
      .rise (req)
   );

   // Decisions use the pre-refill stock, so a refill never rescues a request.
   always_comb begin
      accept      = req && (stock_q != '0) && (pending_q != PEND_FULL);
      lost_sale_d = req && !accept;
   end

   always_comb begin
      state_d    = state_q;
      timer_d    = timer_q;
      motor_en_d = 1'b0;
      item_out_d = 1'b0;
      start      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (pending_q != PEND_ZERO) begin
               state_d    = ST_RUN;
               timer_d    = MOTOR_LOAD;
               motor_en_d = 1'b1;
               start      = 1'b1;
            end
         end
         ST_RUN: begin
            if (timer_q == TIMER_ZERO) begin
               state_d    = ST_SETTLE;
               timer_d    = SETTLE_LOAD;
               item_out_d = 1'b1;
            end else begin
               timer_d    = timer_q - 1'b1;
               motor_en_d = 1'b1;
            end
         end
         ST_SETTLE: begin
            if (timer_q == TIMER_ZERO) begin
               state_d = ST_IDLE;
            end else begin
               timer_d = timer_q - 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            timer_d = TIMER_ZERO;
         end
      endcase
   end

   always_comb begin
      pending_d = pending_q;
      case ({accept, start})
         2'b10:   pending_d = pending_q + PEND_ONE;
         2'b01:   pending_d = pending_q - PEND_ONE;
         default: pending_d = pending_q;
      endcase
   end

   // One spare bit catches the refill overflow before saturating.
   always_comb begin
      stock_sum = {1'b0, stock_q} - {{STOCK_W{1'b0}}, accept};
      if (refill) begin
         stock_sum = stock_sum + {1'b0, refill_count};
      end
      if (stock_sum > STOCK_MAX) begin
         stock_d = STOCK_MAX[STOCK_W-1:0];
      end else begin
         stock_d = stock_sum[STOCK_W-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         timer_q     <= TIMER_ZERO;
         pending_q   <= PEND_ZERO;
         stock_q     <= STOCK_RST;
         motor_en_q  <= 1'b0;
         item_out_q  <= 1'b0;
         lost_sale_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         timer_q     <= timer_d;
         pending_q   <= pending_d;
         stock_q     <= stock_d;
         motor_en_q  <= motor_en_d;
         item_out_q  <= item_out_d;
         lost_sale_q <= lost_sale_d;
      end
   end

   assign motor_en  = motor_en_q;
   assign item_out  = item_out_q;
   assign lost_sale = lost_sale_q;
   assign stock     = stock_q;
   assign pending   = pending_q;
   assign sold_out  = (stock_q == '0);
   assign busy      = (state_q != ST_IDLE) || (pending_q != PEND_ZERO);

endmodule
